// File: rtl/la_pkg.sv
// rtl/la_pkg.sv - shared constants and state type for the logic analyzer capture and generator paths
package la_pkg;

    // Pin width and buffer sizing shared with the capture core.
    localparam int PG_WIDTH = 8;
    localparam int PG_DEPTH = 16;
    localparam int PG_AW    = $clog2(PG_DEPTH);
    localparam int PG_DIV_W = 8;

    typedef enum logic {
        PG_IDLE = 1'b0,
        PG_RUN  = 1'b1
    } pg_state_t;

endpackage

// File: rtl/la_pattern_gen_if.sv
// rtl/la_pattern_gen_if.sv - host load/control bus and pin outputs of the pattern generator
// master: host side (drives load/control, observes status and pins)
// slave:  generator side
interface la_pattern_gen_if
    import la_pkg::*;
#(
    parameter int WIDTH = PG_WIDTH,
    parameter int AW    = PG_AW,
    parameter int DIV_W = PG_DIV_W
);
    logic             load_clr;
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;
    logic [AW:0]      wptr;
    logic             start;
    logic             stop;
    logic             loop_en;
    logic [AW-1:0]    len;
    logic [DIV_W-1:0] div;
    logic [WIDTH-1:0] pat_out;
    logic             pat_oe;
    logic             busy;
    logic             done;

    modport master (
        output load_clr, load_valid, load_data, start, stop, loop_en, len, div,
        input  load_ready, wptr, pat_out, pat_oe, busy, done
    );

    modport slave (
        input  load_clr, load_valid, load_data, start, stop, loop_en, len, div,
        output load_ready, wptr, pat_out, pat_oe, busy, done
    );
endinterface

// File: rtl/la_pg_tick.sv
// rtl/la_pg_tick.sv - playback rate divider, ticks once every div+1 enabled cycles
// clk, rst_n : clock, async active-low reset
// en         : count enable (freezes counter when 0)
// clr        : hold counter at 0 while enabled
// div        : terminal count
// tick       : counter has reached div
module la_pg_tick
    import la_pkg::*;
#(
    parameter int DIV_W = PG_DIV_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    // >= so that lowering div below the running count ends the period next cycle.
    assign tick = (cnt >= div);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en) begin
            if (clr || tick) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/la_pattern_gen.sv
// rtl/la_pattern_gen.sv - pattern memory and playback sequencer driving the uio pins
// clk, rst_n : clock, async active-low reset
// ena        : global enable, freezes all state when 0
// bus        : load port (load_clr/valid/data/ready, wptr), control (start, stop,
//              loop_en, len, div), pin outputs (pat_out, pat_oe) and status (busy, done)
module la_pattern_gen
    import la_pkg::*;
#(
    parameter int WIDTH = PG_WIDTH,
    parameter int DEPTH = PG_DEPTH,
    parameter int AW    = $clog2(DEPTH),
    parameter int DIV_W = PG_DIV_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    la_pattern_gen_if.slave  bus
);

    pg_state_t        state, state_n;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW-1:0]    rptr;
    logic [WIDTH-1:0] pat_out;
    logic             pat_oe;
    logic             done;
    logic             tick;
    logic             do_start, do_adv, do_wrap, do_done;
    logic             wr_fire;
    logic             full;

    assign bus.load_ready = (state == PG_IDLE);
    assign bus.busy       = (state == PG_RUN);
    assign bus.wptr       = wptr;
    assign bus.pat_out    = pat_out;
    assign bus.pat_oe     = pat_oe;
    assign bus.done       = done;

    // Counter is held at 0 through IDLE so the first entry lasts exactly div+1 cycles.
    la_pg_tick #(.DIV_W(DIV_W)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ena),
        .clr   (state == PG_IDLE),
        .div   (bus.div),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= PG_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        do_start = 1'b0;
        do_adv   = 1'b0;
        do_wrap  = 1'b0;
        do_done  = 1'b0;
        if (ena) begin
            case (state)
                PG_IDLE: begin
                    if (bus.start && !bus.stop) begin
                        state_n  = PG_RUN;
                        do_start = 1'b1;
                    end
                end
                PG_RUN: begin
                    if (bus.stop) begin
                        state_n = PG_IDLE;
                    end else if (tick) begin
                        // rptr above a lowered len is handled as the last entry.
                        if (rptr < bus.len) begin
                            do_adv = 1'b1;
                        end else if (bus.loop_en) begin
                            do_wrap = 1'b1;
                        end else begin
                            state_n = PG_IDLE;
                            do_done = 1'b1;
                        end
                    end
                end
                default: state_n = PG_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr    <= '0;
            pat_out <= '0;
            pat_oe  <= 1'b0;
            done    <= 1'b0;
        end else if (ena) begin
            done <= do_done;
            if (do_start) begin
                rptr    <= '0;
                pat_out <= mem[0];
                pat_oe  <= 1'b1;
            end else if (do_adv) begin
                rptr    <= rptr + 1'b1;
                pat_out <= mem[rptr + 1'b1];
            end else if (do_wrap) begin
                rptr    <= '0;
                pat_out <= mem[0];
            end
        end
    end

    // Beats past a full memory are still accepted (ready stays high) but dropped.
    assign full    = wptr[AW];
    assign wr_fire = ena && bus.load_valid && bus.load_ready && !bus.load_clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
        end else if (ena) begin
            if (bus.load_clr) begin
                wptr <= '0;
            end else if (wr_fire && !full) begin
                wptr <= wptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire && !full) begin
            mem[wptr[AW-1:0]] <= bus.load_data;
        end
    end

endmodule

// File: tb/tb_la_pattern_gen.sv
// tb/tb_la_pattern_gen.sv - self-checking bench for la_pattern_gen
module tb_la_pattern_gen;

    logic clk = 1'b0;
    logic rst_n;
    logic ena;

    always #5 clk = ~clk;

    la_pattern_gen_if bus ();

    la_pattern_gen dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (bus)
    );

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    logic [7:0] mmem [16];
    int         mw = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus.load_clr = 1'b1;
        step();
        bus.load_clr = 1'b0;
        mw = 0;
    endtask

    task automatic beat(input logic [7:0] b);
        bus.load_valid = 1'b1;
        bus.load_data  = b;
        step();
        bus.load_valid = 1'b0;
        if (mw < 16) begin
            mmem[mw] = b;
            mw++;
        end
    endtask

    // Expected pins at effective time te after start: entry floor(te/(div+1)),
    // modulo len+1 when looping; otherwise done at te == (len+1)*(div+1), then hold.
    task automatic play(input int ln, input int dv, input bit lp, input int ncyc,
                        input bit do_stop, input int poke_at, input int frz_at);
        int         te;
        int         p;
        int         n;
        logic [7:0] ep;
        logic       eb;
        logic       ed;
        logic [7:0] last;
        p = dv + 1;
        n = ln + 1;
        last = 8'h00;
        bus.len     = ln[3:0];
        bus.div     = dv[7:0];
        bus.loop_en = lp;
        bus.start   = 1'b1;
        step();
        bus.start = 1'b0;
        te = 0;
        for (int c = 0; c < ncyc; c++) begin
            if (lp || te < n * p) begin
                ep = mmem[(te / p) % n];
                eb = 1'b1;
                ed = 1'b0;
            end else begin
                ep = mmem[ln];
                eb = 1'b0;
                ed = (te == n * p);
            end
            chk("pat_out", {24'h0, bus.pat_out}, {24'h0, ep});
            chk("busy", {31'h0, bus.busy}, {31'h0, eb});
            chk("done", {31'h0, bus.done}, {31'h0, ed});
            chk("pat_oe", {31'h0, bus.pat_oe}, 32'h1);
            last = ep;
            ena = !(frz_at >= 0 && c >= frz_at && c < frz_at + 5);
            if (c == poke_at) begin
                bus.start      = 1'b1;
                bus.load_valid = 1'b1;
                bus.load_data  = 8'hEE;
                chk("load_ready_run", {31'h0, bus.load_ready}, 32'h0);
            end
            if (do_stop && c == ncyc - 1) bus.stop = 1'b1;
            step();
            bus.start      = 1'b0;
            bus.load_valid = 1'b0;
            bus.stop       = 1'b0;
            if (ena) te++;
        end
        ena = 1'b1;
        if (do_stop) begin
            chk("stop_busy", {31'h0, bus.busy}, 32'h0);
            chk("stop_done", {31'h0, bus.done}, 32'h0);
            chk("stop_hold", {24'h0, bus.pat_out}, {24'h0, last});
            step();
            chk("stop_hold2", {24'h0, bus.pat_out}, {24'h0, last});
            chk("stop_done2", {31'h0, bus.done}, 32'h0);
        end
    endtask

    initial begin
        int ln;
        int dv;
        bit lp;
        rst_n          = 1'b0;
        ena            = 1'b1;
        bus.load_clr   = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = 8'h00;
        bus.start      = 1'b0;
        bus.stop       = 1'b0;
        bus.loop_en    = 1'b0;
        bus.len        = 4'h0;
        bus.div        = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pat_out", {24'h0, bus.pat_out}, 32'h0);
        chk("rst_pat_oe", {31'h0, bus.pat_oe}, 32'h0);
        chk("rst_busy", {31'h0, bus.busy}, 32'h0);
        chk("rst_done", {31'h0, bus.done}, 32'h0);
        chk("rst_wptr", {27'h0, bus.wptr}, 32'h0);
        chk("rst_load_ready", {31'h0, bus.load_ready}, 32'h1);
        rst_n = 1'b1;
        step();

        beat(8'h11); beat(8'h22); beat(8'h33); beat(8'h44);
        chk("wptr_4", {27'h0, bus.wptr}, 32'd4);

        play(3, 0, 1'b0, 7, 1'b0, -1, -1);
        play(1, 2, 1'b1, 11, 1'b1, -1, -1);
        play(3, 3, 1'b0, 24, 1'b0, -1, 6);

        bus.start = 1'b1;
        bus.stop  = 1'b1;
        step();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        chk("start_stop_busy", {31'h0, bus.busy}, 32'h0);
        step();
        chk("start_stop_busy2", {31'h0, bus.busy}, 32'h0);

        play(3, 1, 1'b0, 12, 1'b0, 2, -1);
        chk("wptr_after_run_beat", {27'h0, bus.wptr}, 32'd4);

        clr();
        for (int i = 0; i < 20; i++) beat(8'($urandom));
        chk("wptr_sat", {27'h0, bus.wptr}, 32'd16);
        play(15, 0, 1'b0, 18, 1'b0, -1, -1);

        for (int r = 0; r < 8; r++) begin
            ln = $urandom_range(0, 15);
            dv = $urandom_range(0, 3);
            lp = 1'($urandom_range(0, 1));
            if (lp) play(ln, dv, 1'b1, $urandom_range(5, 40), 1'b1, -1, -1);
            else    play(ln, dv, 1'b0, (ln + 1) * (dv + 1) + 2, 1'b0, -1, -1);
        end

        clr();
        beat(8'hAA);
        chk("wptr_after_clr", {27'h0, bus.wptr}, 32'd1);
        play(0, 0, 1'b0, 3, 1'b0, -1, -1);

        bus.load_clr   = 1'b1;
        bus.load_valid = 1'b1;
        bus.load_data  = 8'h55;
        step();
        bus.load_clr   = 1'b0;
        bus.load_valid = 1'b0;
        mw = 0;
        chk("clr_priority_wptr", {27'h0, bus.wptr}, 32'd0);
        play(0, 1, 1'b0, 4, 1'b0, -1, -1);

        bus.len     = 4'd0;
        bus.div     = 8'd3;
        bus.loop_en = 1'b1;
        bus.start   = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (5) step();
        chk("pre_rst_busy", {31'h0, bus.busy}, 32'h1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_pat_out", {24'h0, bus.pat_out}, 32'h0);
        chk("async_rst_pat_oe", {31'h0, bus.pat_oe}, 32'h0);
        chk("async_rst_busy", {31'h0, bus.busy}, 32'h0);
        chk("async_rst_done", {31'h0, bus.done}, 32'h0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_load_ready", {31'h0, bus.load_ready}, 32'h1);
        chk("post_rst_wptr", {27'h0, bus.wptr}, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/la_pattern_gen.md
Name: la_pattern_gen

Overview:
Stimulus-side counterpart to the logic analyzer capture path. The analyzer records pins; this block plays back a stored pattern onto pins.
- Host loads up to DEPTH words through a valid/ready byte interface.
- On start, the block replays the words at a programmable rate, once or looping.
- It sits beside the capture core inside the top-level TinyTapeout wrapper and drives the uio pins when the wrapper selects generator mode.

Parameters:
WIDTH, 8, pattern word width (= uio pin count)
DEPTH, 16, pattern memory entries (power of two)
AW, 4, address width = log2(DEPTH)
DIV_W, 8, rate divider width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  global enable; when 0, all state, counters and outputs freeze
load_clr  in  1  sync pulse; clears write pointer to 0
load_valid  in  1  load word valid
load_data  in  WIDTH  load word
load_ready  out  1  1 only in IDLE; a write occurs when valid & ready & ena
wptr  out  AW+1  number of words written, saturates at DEPTH
start  in  1  sync pulse; begin playback (IDLE only)
stop  in  1  sync pulse; abort playback
loop_en  in  1  1: wrap to entry 0 after last entry
len  in  AW  index of last entry to play (plays len+1 entries)
div  in  DIV_W  each entry is held div+1 cycles
pat_out  out  WIDTH  registered pattern output
pat_oe  out  1  output enable for uio pins
busy  out  1  1 while in RUN
done  out  1  one-cycle pulse on natural completion

Behaviour:
- Reset values: pat_out=0, pat_oe=0, busy=0, done=0, wptr=0, state=IDLE, load_ready=1. Memory contents are not reset.
- State machine has two states, IDLE and RUN. done is a registered pulse, not a state.
- Load (IDLE):
  - Each accepted beat writes mem[wptr[AW-1:0]] and increments wptr.
  - At wptr=DEPTH, further beats are accepted but dropped, and wptr holds.
  - load_clr takes priority over a same-cycle write; that write is dropped.
- Start: start=1 in IDLE at edge k.
  - After edge k: state=RUN, busy=1, pat_oe=1, pat_out=mem[0], rptr=0, divider cnt=0.
  - start in RUN is ignored.
- Advance: while in RUN, cnt increments each cycle. When cnt==div, cnt returns to 0 and:
  - if rptr<len: rptr+1 and pat_out=mem[rptr+1];
  - if rptr==len and loop_en=1: rptr=0 and pat_out=mem[0];
  - if rptr==len and loop_en=0: state=IDLE, busy=0, done=1 for one cycle, pat_out holds the last entry.
- Timing: entry i appears at edge k+i*(div+1). done asserts at edge k+(len+1)*(div+1).
- loop_en is sampled at each wrap decision, so clearing it mid-run ends playback after the current pass.
- len and div are sampled continuously:
  - lowering len below rptr takes effect at the next advance (rptr>len is treated as rptr==len);
  - lowering div below cnt takes effect on the next cycle (cnt>=div is treated as cnt==div).
- Stop:
  - stop in RUN leads to IDLE next edge, busy=0, no done pulse, pat_out holds.
  - stop in the same cycle as start leaves the block in IDLE (stop has priority).
- pat_oe:
  - set on the first start after reset;
  - stays 1 through IDLE, so the pins keep driving the held value;
  - cleared only by rst_n.
- Reads of entries at or above wptr return stale or uninitialised memory; sequencing this is the host's responsibility.
- ena=0 freezes FSM, counters, pointers and outputs. start, stop, load_clr and load beats arriving while ena=0 are dropped.
- Reset mid-RUN returns asynchronously to reset values; pat_oe drops immediately.

Decomposition:
- Shared package la_pkg holds:
  - pg_state_t enum (PG_IDLE, PG_RUN);
  - PG_WIDTH, PG_DEPTH and PG_DIV_W constants, shared with the capture core so pin width and buffer sizing match.
- Sub-module la_pg_tick: divider counter with inputs clr, en, div and output tick (cnt==div). The FSM and memory stay in la_pattern_gen.

Test Plan:
- Load 0x11,0x22,0x33,0x44; start with len=3, div=0, loop_en=0 -> pat_out shows 11,22,33,44 on consecutive cycles; done pulses once 4 cycles after start; busy=0 afterwards; pat_out stays 0x44.
- Same memory, div=2, len=1, loop_en=1 -> sequence 11,11,11,22,22,22,11,... with no done pulse; stop at cycle 10 -> busy=0 next cycle, pat_out holds, no done pulse.
- Load 20 beats with DEPTH=16 -> wptr stops at 16; beats 17–20 are dropped. load_clr then writing 0xAA -> mem[0]=0xAA, wptr=1.
- Start and stop asserted in the same cycle -> busy stays 0. Start during RUN -> no restart (rptr continues). Load beat during RUN -> load_ready=0 and memory is unchanged.
- ena=0 for 5 cycles mid-run with div=3 -> pat_out and cnt frozen; after ena returns to 1, timing resumes exactly, shifted by 5 cycles.
- Assert rst_n=0 mid-run, asynchronously between clock edges -> pat_out=0, pat_oe=0, busy=0 before the next edge; after release, load_ready=1 and wptr=0.
